// File: rtl/sm83_pkg.sv
// Shared SM83 front-end types: fetch sequencer states, special opcodes and
// the ALU-class opcode test used by the decoder and by tests.
package sm83_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_CB_FETCH = 3'd1,
        ST_EXEC     = 3'd2,
        ST_HALT     = 3'd3,
        ST_DISPATCH = 3'd4
    } state_t;

    localparam logic [7:0] OP_PREFIX_CB = 8'hCB;
    localparam logic [7:0] OP_HALT      = 8'h76;
    localparam logic [7:0] OP_NOP       = 8'h00;

    // 8-bit ALU ops: ALU r/(HL) is 10xxxxxx, ALU n is 11xxx110; never in the CB bank.
    function automatic logic is_alu_op(input logic [7:0] op, input logic cb);
        return !cb && ((op[7:6] == 2'b10) || ((op[7:6] == 2'b11) && (op[2:0] == 3'b110)));
    endfunction

endpackage

// File: rtl/sm83_opfetch.sv
// SM83 opcode fetch sequencer: captures opcodes (incl. CB prefix), tracks
// HALT, the halt bug and interrupt dispatch, and drives PC increment pulses.
module sm83_opfetch
    import sm83_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       op_done,
    input  logic       irq_pending,
    input  logic       ime,
    output logic [7:0] opcode,
    output logic       bank_cb,
    output logic       in_halt,
    output logic       in_alu,
    output logic       fetch_req,
    output logic       pc_inc,
    output logic       dispatch
);

    state_t     r_state;
    logic [7:0] r_opcode;
    logic       r_bank_cb;
    logic       r_in_halt;
    logic       r_in_alu;
    logic       r_pc_inc;
    logic       r_dispatch;
    logic       r_halt_bug;

    logic       w_take_irq;

    assign w_take_irq = irq_pending & ime;
    assign fetch_req  = (r_state == ST_FETCH) || (r_state == ST_CB_FETCH);

    assign opcode   = r_opcode;
    assign bank_cb  = r_bank_cb;
    assign in_halt  = r_in_halt;
    assign in_alu   = r_in_alu;
    assign pc_inc   = r_pc_inc;
    assign dispatch = r_dispatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_FETCH;
            r_opcode   <= OP_NOP;
            r_bank_cb  <= 1'b0;
            r_in_halt  <= 1'b0;
            r_in_alu   <= 1'b0;
            r_pc_inc   <= 1'b0;
            r_dispatch <= 1'b0;
            r_halt_bug <= 1'b0;
        end else begin
            r_pc_inc <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (data_valid) begin
                        r_opcode   <= data_in;
                        r_bank_cb  <= 1'b0;
                        r_in_alu   <= is_alu_op(data_in, 1'b0);
                        // A pending halt bug swallows exactly this one increment.
                        r_pc_inc   <= !r_halt_bug;
                        r_halt_bug <= 1'b0;
                        if (data_in == OP_PREFIX_CB) begin
                            r_state <= ST_CB_FETCH;
                        end else if (data_in == OP_HALT) begin
                            if (!irq_pending) begin
                                r_state   <= ST_HALT;
                                r_in_halt <= 1'b1;
                            end else if (ime) begin
                                r_state    <= ST_DISPATCH;
                                r_opcode   <= OP_NOP;
                                r_in_alu   <= 1'b0;
                                r_dispatch <= 1'b1;
                            end else begin
                                r_state    <= ST_FETCH;
                                r_halt_bug <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end

                ST_CB_FETCH: begin
                    if (data_valid) begin
                        r_opcode  <= data_in;
                        r_bank_cb <= 1'b1;
                        r_in_alu  <= is_alu_op(data_in, 1'b1);
                        r_pc_inc  <= 1'b1;
                        r_state   <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (op_done) begin
                        if (w_take_irq) begin
                            r_state    <= ST_DISPATCH;
                            r_opcode   <= OP_NOP;
                            r_bank_cb  <= 1'b0;
                            r_in_alu   <= 1'b0;
                            r_dispatch <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end

                ST_HALT: begin
                    // in_halt drops on wake; the exit itself happens one cycle later.
                    if (r_in_halt) begin
                        if (irq_pending) begin
                            r_in_halt <= 1'b0;
                        end
                    end else if (ime) begin
                        r_state    <= ST_DISPATCH;
                        r_opcode   <= OP_NOP;
                        r_bank_cb  <= 1'b0;
                        r_in_alu   <= 1'b0;
                        r_dispatch <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end

                ST_DISPATCH: begin
                    if (op_done) begin
                        r_dispatch <= 1'b0;
                        r_state    <= ST_FETCH;
                    end
                end

                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/sm83_opfetch.md
SM83_OPFETCH -- requirements
Module: sm83_opfetch

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 data_in  in  8  memory read data at PC.
REQ-005 data_valid  in  1  data_in is valid this cycle and consumes the pending fetch.
REQ-006 op_done  in  1  execution unit is in the last cycle of the current instruction or dispatch.
REQ-007 irq_pending  in  1  at least one enabled interrupt is requested.
REQ-008 ime  in  1  interrupt master enable.
REQ-009 opcode  out  8  registered opcode presented to the decoder.
REQ-010 bank_cb  out  1  opcode belongs to the CB-prefixed bank.
REQ-011 in_halt  out  1  CPU is halted.
REQ-012 in_alu  out  1  opcode is an 8-bit ALU op: ALU r/(HL) or ALU n.
REQ-013 fetch_req  out  1  requests an opcode read at PC.
REQ-014 pc_inc  out  1  one-cycle pulse telling the PC unit to increment.
REQ-015 dispatch  out  1  interrupt dispatch sequence is in progress.

Function
REQ-016 SHALL implement the states FETCH, CB_FETCH, EXEC, HALT and DISPATCH.
REQ-017 fetch_req SHALL be 1 exactly in FETCH and CB_FETCH, decoded from the state register; all other outputs SHALL be registered.
REQ-018 FETCH with data_valid=0: hold state and all outputs.
REQ-019 FETCH with data_valid=1: opcode<=data_in, bank_cb<=0, pc_inc=1 the same cycle (except the halt-bug case, REQ-026).
REQ-020 After the FETCH capture, the next state SHALL be CB_FETCH if data_in=0xCB, HALT-entry per REQ-025 if data_in=0x76, otherwise EXEC.
REQ-021 CB_FETCH with data_valid=1: opcode<=data_in, bank_cb<=1, pc_inc=1, next state EXEC.
REQ-022 in_alu SHALL be loaded at every opcode capture as !cb & (op[7:6]=2 | (op[7:6]=3 & op[2:0]=6)); it SHALL be 0 in the CB bank, HALT and DISPATCH.
REQ-023 EXEC with op_done=1: go to DISPATCH if irq_pending & ime, else go to FETCH; hold EXEC while op_done=0.
REQ-024 Entering DISPATCH: opcode<=0x00, bank_cb<=0, in_alu<=0, dispatch<=1; on op_done go to FETCH with dispatch<=0.
REQ-025 Fetch of 0x76: if irq_pending=0, enter HALT with in_halt<=1; if irq_pending=1 & ime=1, enter DISPATCH; if irq_pending=1 & ime=0, enter FETCH with the halt-bug flag set.
REQ-026 Halt bug: the next accepted fetch SHALL produce no pc_inc, then SHALL clear the flag; at most one suppressed increment per HALT.
REQ-027 HALT: fetch_req=0 and pc_inc=0; on irq_pending=1, in_halt<=0, then go to DISPATCH if ime=1, else FETCH, one cycle later; data_valid is ignored.
REQ-028 A pending CB prefix SHALL never be interrupted: an irq during CB_FETCH is only evaluated at the following op_done.
REQ-029 op_done SHALL be ignored outside EXEC and DISPATCH.
REQ-030 data_valid SHALL be ignored outside FETCH and CB_FETCH.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately force: state=FETCH, opcode=0x00, bank_cb=0, in_halt=0, in_alu=0, pc_inc=0, dispatch=0, halt-bug flag=0.
REQ-032 Reset mid-instruction SHALL abandon the instruction; fetch_req=1 from the first cycle after reset deasserts.

Structure
REQ-033 The state enum and constants OP_PREFIX_CB=0xCB, OP_HALT=0x76 and OP_NOP=0x00 SHALL live in the shared sm83_pkg package.
REQ-034 SHALL be one flat module with no sub-modules; the ALU-class test SHALL be a package function reused by tests.

Verification
REQ-035 Reset, then feed 0x80 with valid, then op_done: opcode=0x80, in_alu=1, bank_cb=0, one pc_inc, back in FETCH.
REQ-036 Feed 0xCB then 0x37: two pc_inc pulses, opcode=0x37, bank_cb=1, in_alu=0; no fetch_req while in EXEC.
REQ-037 Feed 0x76 with irq_pending=0: in_halt=1, fetch_req=0; raise irq_pending with ime=1: in_halt=0, dispatch=1, opcode=0x00; op_done returns to FETCH.
REQ-038 Feed 0x76 with irq_pending=1 and ime=0: no HALT; next fetch of 0x3C gives pc_inc=0, the following fetch gives pc_inc=1.
REQ-039 EXEC 0xFE with irq_pending=1, ime=1 at op_done: DISPATCH next cycle; asserting reset_n mid-DISPATCH gives all outputs at reset values and fetch_req=1 after release.
